axi_wr_arbiter: RTL and testbench

- Shares one AXI write slave port (the single-port write FSM plus memory) between NUM_M write masters.
- Round-robin arbitration on AW. The grant is held for the whole transaction: AW, then all W beats, then B.
- Counts W beats against the latched AWLEN, drives the slave-side WLAST itself, and flags length mismatches in BRESP.
- Sits between the master-side interconnect and the slave write FSM.

---
 rtl/axi_wr_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write slave port between NUM_M masters.
// Optional response-wait timeout is compiled in with the ARB_TIMEOUT_EN macro.
module axi_wr_arbiter #(
  parameter int NUM_M   = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_M-1:0]    m_awvalid,
  output logic [NUM_M-1:0]    m_awready,
  input  logic [NUM_M*AW-1:0] m_awaddr,
  input  logic [NUM_M*8-1:0]  m_awlen,
  input  logic [NUM_M*2-1:0]  m_awburst,
  input  logic [NUM_M-1:0]    m_wvalid,
  output logic [NUM_M-1:0]    m_wready,
  input  logic [NUM_M*DW-1:0] m_wdata,
  input  logic [NUM_M-1:0]    m_wlast,
  output logic [NUM_M-1:0]    m_bvalid,
  output logic [NUM_M*2-1:0]  m_bresp,
  input  logic [NUM_M-1:0]    m_bready,
  output logic                s_awvalid,
  output logic [AW-1:0]       s_awaddr,
  output logic [7:0]          s_awlen,
  output logic [1:0]          s_awburst,
  input  logic                s_awready,
  output logic                s_wvalid,
  output logic [DW-1:0]       s_wdata,
  output logic                s_wlast,
  input  logic                s_wready,
  input  logic                s_bvalid,
  input  logic [1:0]          s_bresp,
  output logic                s_bready,
  output logic [2:0]          grant_id,
  output logic                busy,
  output logic [1:0]          state_dbg
);

  // Handshakes: a transfer happens in the cycle where valid && ready are both
  // high; valid never waits on ready, and only the granted master is connected.

  localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]    state;
  logic [GW-1:0] g;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] winner;
  logic          any_req;
  logic [7:0]    beat_cnt;
  logic [7:0]    len_q;
  logic          len_err;
  logic          b_valid_g;
  logic [1:0]    b_resp_g;
  logic          b_fire;

  logic [AW-1:0] awaddr_a  [NUM_M];
  logic [7:0]    awlen_a   [NUM_M];
  logic [1:0]    awburst_a [NUM_M];
  logic [DW-1:0] wdata_a   [NUM_M];

  logic [2*NUM_M-1:0] req2;
  logic [NUM_M-1:0]   req_rot;

  always_comb begin
    for (int i = 0; i < NUM_M; i++) begin
      awaddr_a[i]  = m_awaddr[i*AW +: AW];
      awlen_a[i]   = m_awlen[i*8 +: 8];
      awburst_a[i] = m_awburst[i*2 +: 2];
      wdata_a[i]   = m_wdata[i*DW +: DW];
    end
  end

  // Rotate requests so bit 0 is the master right after last_grant; the lowest
  // set bit of the rotated vector is the winner.
  always_comb begin
    req2    = {m_awvalid, m_awvalid};
    req_rot = NUM_M'(req2 >> (int'(last_grant) + 1));
    winner  = last_grant;
    any_req = 1'b0;
    for (int j = NUM_M - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        any_req = 1'b1;
        winner  = GW'((int'(last_grant) + 1 + j) % NUM_M);
      end
    end
  end

  always_comb begin
    s_awvalid = (state == ADDR) && m_awvalid[g];
    s_awaddr  = awaddr_a[g];
    s_awlen   = awlen_a[g];
    s_awburst = awburst_a[g];
    m_awready = '0;
    if (state == ADDR) m_awready[g] = s_awready;

    s_wvalid = (state == DATA) && m_wvalid[g];
    s_wdata  = wdata_a[g];
    s_wlast  = (state == DATA) && (beat_cnt == len_q);
    m_wready = '0;
    if (state == DATA) m_wready[g] = s_wready;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] to_cnt;
  logic          to_fired;

  assign to_fired = (to_cnt == TW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst_n || state != RESP) to_cnt <= '0;
    else if (!s_bvalid && !to_fired) to_cnt <= to_cnt + 1'b1;
  end

  // Once fired, the arbiter answers the master itself; a late slave B is
  // swallowed in IDLE so it cannot leak into the next transaction.
  always_comb begin
    b_valid_g = to_fired ? 1'b1 : s_bvalid;
    b_resp_g  = (to_fired || len_err) ? 2'b10 : s_bresp;
    s_bready  = 1'b0;
    if (state == RESP)      s_bready = to_fired ? 1'b0 : m_bready[g];
    else if (state == IDLE) s_bready = s_bvalid;
  end
`else
  always_comb begin
    b_valid_g = s_bvalid;
    b_resp_g  = len_err ? 2'b10 : s_bresp;
    s_bready  = (state == RESP) && m_bready[g];
  end
`endif

  always_comb begin
    m_bvalid = '0;
    m_bresp  = '0;
    if (state == RESP) begin
      m_bvalid[g] = b_valid_g;
      for (int i = 0; i < NUM_M; i++) begin
        if (GW'(i) == g) m_bresp[i*2 +: 2] = b_resp_g;
      end
    end
  end

  assign b_fire = (state == RESP) && b_valid_g && m_bready[g];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      g          <= '0;
      last_grant <= GW'(NUM_M - 1);
      beat_cnt   <= '0;
      len_q      <= '0;
      len_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            g     <= winner;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (s_awvalid && s_awready) begin
            len_q    <= s_awlen;
            beat_cnt <= '0;
            len_err  <= 1'b0;
            state    <= DATA;
          end
        end
        DATA: begin
          // The beat count, not the master's WLAST, decides where the burst ends.
          if (s_wvalid && s_wready) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (m_wlast[g] != s_wlast) len_err <= 1'b1;
            if (s_wlast) state <= RESP;
          end
        end
        RESP: begin
          if (b_fire) begin
            last_grant <= g;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant_id  = 3'(g);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Randomized bench for axi_wr_arbiter against a transaction-level round-robin model.
module tb_axi_wr_arbiter;
  localparam int NUM_M   = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NUM_M-1:0]    m_awvalid = '0;
  logic [NUM_M-1:0]    m_awready;
  logic [NUM_M*AW-1:0] m_awaddr = '0;
  logic [NUM_M*8-1:0]  m_awlen = '0;
  logic [NUM_M*2-1:0]  m_awburst = '0;
  logic [NUM_M-1:0]    m_wvalid = '0;
  logic [NUM_M-1:0]    m_wready;
  logic [NUM_M*DW-1:0] m_wdata = '0;
  logic [NUM_M-1:0]    m_wlast = '0;
  logic [NUM_M-1:0]    m_bvalid;
  logic [NUM_M*2-1:0]  m_bresp;
  logic [NUM_M-1:0]    m_bready = '0;
  logic                s_awvalid;
  logic [AW-1:0]       s_awaddr;
  logic [7:0]          s_awlen;
  logic [1:0]          s_awburst;
  logic                s_awready = 1'b0;
  logic                s_wvalid;
  logic [DW-1:0]       s_wdata;
  logic                s_wlast;
  logic                s_wready = 1'b0;
  logic                s_bvalid = 1'b0;
  logic [1:0]          s_bresp = 2'b00;
  logic                s_bready;
  logic [2:0]          grant_id;
  logic                busy;
  logic [1:0]          state_dbg;

  always #5 clk = ~clk;

  axi_wr_arbiter #(.NUM_M(NUM_M), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awburst(s_awburst), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wlast(s_wlast), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .grant_id(grant_id), .busy(busy), .state_dbg(state_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  // Reference model: per-master pending request and the last master served.
  bit            pend    [NUM_M];
  logic [AW-1:0] addr_m  [NUM_M];
  logic [7:0]    len_m   [NUM_M];
  logic [1:0]    burst_m [NUM_M];
  int            wl_pos  [NUM_M];
  int            last_g;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NUM_M-1:0] oh(input int i);
    logic [NUM_M-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int rr_pick();
    for (int k = 1; k <= NUM_M; k++) begin
      if (pend[(last_g + k) % NUM_M]) return (last_g + k) % NUM_M;
    end
    return -1;
  endfunction

  // len < 0 picks a random length; wl_pos is the beat where the master raises
  // WLAST (len+1 means never).
  task automatic new_req(input int i, input int len, input bit honest);
    pend[i]    = 1'b1;
    addr_m[i]  = $urandom;
    burst_m[i] = 2'($urandom_range(0, 2));
    if (len >= 0) len_m[i] = 8'(len);
    else if ($urandom_range(0, 9) == 0) len_m[i] = 8'($urandom_range(0, 255));
    else len_m[i] = 8'($urandom_range(0, 7));
    if (honest || $urandom_range(0, 3) != 0) wl_pos[i] = int'(len_m[i]);
    else wl_pos[i] = $urandom_range(0, int'(len_m[i]) + 1);
  endtask

  task automatic drive_aw();
    for (int i = 0; i < NUM_M; i++) begin
      m_awvalid[i]           = pend[i];
      m_awaddr[i*AW +: AW]   = addr_m[i];
      m_awlen[i*8 +: 8]      = len_m[i];
      m_awburst[i*2 +: 2]    = burst_m[i];
    end
  endtask

  // One full transaction starting from an IDLE cycle and ending back in IDLE.
  task automatic run_round();
    int w, b;
    bit mv, sv, mb, err;
    logic [DW-1:0] d;
    logic [1:0] sr;
    w = rr_pick();
    drive_aw();
    #1;
    check("idle_busy", busy, 0);
    check("idle_awready", m_awready, 0);
    tick();
    #1;
    check("grant_id", grant_id, w);
    check("grant_busy", busy, 1);
    repeat ($urandom_range(0, 2)) begin
      check("aw_wait_valid", s_awvalid, 1);
      check("aw_wait_ready", m_awready, 0);
      tick();
    end
    s_awready = 1'b1;
    #1;
    check("s_awvalid", s_awvalid, 1);
    check("s_awaddr", s_awaddr, addr_m[w]);
    check("s_awlen", s_awlen, len_m[w]);
    check("s_awburst", s_awburst, burst_m[w]);
    check("m_awready", m_awready, oh(w));
    tick();
    s_awready = 1'b0;
    pend[w] = 1'b0;
    for (int i = 0; i < NUM_M; i++)
      if (!pend[i] && i != w && $urandom_range(0, 3) == 0) new_req(i, -1, 1'b0);
    drive_aw();
    b = 0;
    while (b <= int'(len_m[w])) begin
      mv = ($urandom_range(0, 3) != 0);
      sv = ($urandom_range(0, 3) != 0);
      d  = $urandom;
      m_wvalid = NUM_M'($urandom);
      m_wlast  = NUM_M'($urandom);
      for (int i = 0; i < NUM_M; i++) m_wdata[i*DW +: DW] = $urandom;
      m_wvalid[w] = mv;
      m_wlast[w]  = (b == wl_pos[w]);
      m_wdata[w*DW +: DW] = d;
      s_wready = sv;
      #1;
      check("s_wvalid", s_wvalid, mv);
      check("m_wready", m_wready, sv ? oh(w) : '0);
      check("s_wlast", s_wlast, b == int'(len_m[w]));
      check("data_awready", m_awready, 0);
      check("data_grant", grant_id, w);
      if (mv && sv) begin
        exp_q.push_back(d);
        check("s_wdata", s_wdata, exp_q.pop_front());
        b++;
      end
      tick();
    end
    m_wvalid = '0;
    m_wlast  = '0;
    s_wready = 1'b0;
    err = (wl_pos[w] != int'(len_m[w]));
    sr  = 2'($urandom_range(0, 3));
    repeat ($urandom_range(0, 3)) begin
      m_bready = NUM_M'($urandom);
      #1;
      check("b_wait_valid", m_bvalid, 0);
      check("b_wait_sready", s_bready, m_bready[w]);
      tick();
    end
    for (int t = 0; t < 4; t++) begin
      mb = (t == 3) ? 1'b1 : 1'($urandom_range(0, 1));
      m_bready = NUM_M'($urandom);
      m_bready[w] = mb;
      s_bvalid = 1'b1;
      s_bresp  = sr;
      #1;
      check("m_bvalid", m_bvalid, oh(w));
      check("m_bresp", m_bresp[w*2 +: 2], err ? 2'b10 : sr);
      check("s_bready", s_bready, mb);
      tick();
      if (mb) break;
    end
    s_bvalid = 1'b0;
    m_bready = '0;
    last_g = w;
  endtask

  initial begin
    int any;
    for (int i = 0; i < NUM_M; i++) begin
      pend[i] = 1'b0; addr_m[i] = '0; len_m[i] = '0; burst_m[i] = '0; wl_pos[i] = 0;
    end
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_state", state_dbg, 0);
    check("rst_grant", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_awready", m_awready, 0);
    check("rst_wready", m_wready, 0);
    check("rst_bvalid", m_bvalid, 0);
    check("rst_s_valids", {s_awvalid, s_wvalid, s_bready}, 0);
    rst_n = 1'b1;
    last_g = NUM_M - 1;

    // All masters requesting single beats: strict rotation 0,1,2,3 then 0.
    for (int i = 0; i < NUM_M; i++) new_req(i, 0, 1'b1);
    for (int r = 0; r < NUM_M; r++) run_round();
    new_req(0, 0, 1'b1);
    run_round();

    // Master 1 raises WLAST on beat 2 of a 4-beat burst.
    for (int i = 0; i < NUM_M; i++) pend[i] = 1'b0;
    new_req(1, 3, 1'b1);
    wl_pos[1] = 1;
    run_round();

    repeat (40) begin
      any = 0;
      for (int i = 0; i < NUM_M; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) new_req(i, -1, 1'b0);
        if (pend[i]) any = 1;
      end
      if (any == 0) new_req($urandom_range(0, NUM_M - 1), -1, 1'b0);
      run_round();
    end

    // Reset in the middle of a 4-beat burst from master 0.
    for (int i = 0; i < NUM_M; i++) pend[i] = 1'b0;
    new_req(0, 3, 1'b1);
    drive_aw();
    tick();
    s_awready = 1'b1;
    tick();
    s_awready = 1'b0;
    pend[0] = 1'b0;
    drive_aw();
    m_wvalid[0] = 1'b1;
    s_wready = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    m_wvalid = '0;
    s_wready = 1'b0;
    #1;
    check("mid_rst_state", state_dbg, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_grant", grant_id, 0);
    check("mid_rst_wready", m_wready, 0);
    check("mid_rst_bvalid", m_bvalid, 0);
    check("mid_rst_swvalid", s_wvalid, 0);
    rst_n = 1'b1;
    last_g = NUM_M - 1;
    new_req(1, -1, 1'b0);
    new_req(3, -1, 1'b0);
    run_round();
    run_round();

`ifdef ARB_TIMEOUT_EN
    new_req(2, 0, 1'b1);
    drive_aw();
    tick();
    s_awready = 1'b1;
    tick();
    s_awready = 1'b0;
    pend[2] = 1'b0;
    drive_aw();
    m_wvalid[2] = 1'b1;
    m_wlast[2]  = 1'b1;
    s_wready    = 1'b1;
    tick();
    m_wvalid = '0;
    m_wlast  = '0;
    s_wready = 1'b0;
    for (int k = 0; k < TIMEOUT; k++) begin
      #1;
      check("to_wait_bvalid", m_bvalid, 0);
      tick();
    end
    #1;
    check("to_bvalid", m_bvalid, oh(2));
    check("to_bresp", m_bresp[5:4], 2'b10);
    check("to_sbready", s_bready, 0);
    m_bready[2] = 1'b1;
    tick();
    m_bready = '0;
    last_g = 2;
    #1;
    check("to_idle", busy, 0);
    s_bvalid = 1'b1;
    #1;
    check("to_absorb", s_bready, 1);
    s_bvalid = 1'b0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
